sixbitacos: RTL

//  Sequential inverse of the six-bit truncated cosine (1 - x^2/2 + x^4/24).

---
 rtl/sixbitacos.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sixbitacos.sv
// ---------------------------------------------------------------------------
// sixbitacos
//   Sequential inverse of the six-bit truncated cosine f(x) = 1 - x^2/2 + x^4/24.
//   On an accepted start the block walks x = 0..MAX_X, one candidate per
//   cycle, and reports the smallest x whose f(x) equals the latched target,
//   together with the overflow flag produced while evaluating f(x).
//
// Parameters
//   MAX_X     last candidate scanned (0..63)
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   start     in   1  search request, honoured only while idle
//   target    in   6  value to invert, captured when start is accepted
//   busy      out  1  high while candidates are being evaluated
//   done      out  1  single-cycle pulse: found/result/overflow are valid
//   found     out  1  a matching x exists; held until the next accepted start
//   result    out  6  smallest matching x, 0 when none; held
//   overflow  out  1  overflow flag of f(result), 0 when none; held
// ---------------------------------------------------------------------------
module sixbitacos #(
    parameter int MAX_X = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] target,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [5:0] result,
    output logic       overflow
);

    localparam logic [5:0] LAST_X = 6'(MAX_X);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic [5:0]  x_q,        x_d;
    logic [5:0]  target_q,   target_d;
    logic        found_q,    found_d;
    logic [5:0]  result_q,   result_d;
    logic        overflow_q, overflow_d;

    logic [5:0]  cand_f;
    logic        cand_ovf;

    // Combinational evaluator. Returns {ovf, f}. Every intermediate is kept at
    // full width so the overflow terms can be judged before truncation.
    function automatic logic [6:0] eval_f(input logic [5:0] x);
        logic [11:0] p2;
        logic [11:0] t1;
        logic [5:0]  s;
        logic [23:0] p4;
        logic [23:0] t2;
        logic [24:0] sum;
        logic        o0, o1, o2, o3;
        p2  = 12'(x) * 12'(x);
        o0  = p2 > 12'd63;
        t1  = o0 ? 12'd0 : (p2 >> 1);
        // Subtraction wraps modulo 64; a borrow out of 1 - t1 happens exactly when t1 > 1.
        s   = 6'(12'd1 - t1);
        o1  = t1 > 12'd1;
        p4  = 24'(p2) * 24'(p2);
        o2  = p4 > 24'd63;
        t2  = o2 ? 24'd0 : (p4 / 24'd24);
        sum = 25'(s) + 25'(t2);
        o3  = sum > 25'd63;
        return {o0 | o1 | o2 | o3, sum[5:0]};
    endfunction

    always_comb begin
        {cand_ovf, cand_f} = eval_f(x_q);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        x_d        = x_q;
        target_d   = target_q;
        found_d    = found_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d   = target;
                    x_d        = 6'd0;
                    found_d    = 1'b0;
                    result_d   = 6'd0;
                    overflow_d = 1'b0;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cand_f == target_q) begin
                    result_d   = x_q;
                    found_d    = 1'b1;
                    overflow_d = cand_ovf;
                    state_d    = S_DONE;
                end else if (x_q == LAST_X) begin
                    result_d   = 6'd0;
                    found_d    = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= 6'd0;
            target_q   <= 6'd0;
            found_q    <= 1'b0;
            result_q   <= 6'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            target_q   <= target_d;
            found_q    <= found_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == S_SEARCH);
    assign done     = (state_q == S_DONE);
    assign found    = found_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule
